// File: rtl/glitc_trigger_discriminator.sv
// glitc_trigger_discriminator
// Trigger discriminator that sits after the dual-RITC correlator. Each
// sysclk it takes the two per-RITC maximum correlation values and compares
// them against programmable thresholds. It combines the two results using the
// selected coincidence mode and then issues a one-cycle trigger, followed by a
// programmable holdoff. For every trigger it captures the correlation values
// that caused it, and it keeps per-period rate scalers.
//
// Ports:
//   sysclk_i        system clock, all logic on the rising edge
//   rst_n_i         asynchronous active-low reset
//   r0_max_i        RITC0 max correlation, new value every cycle
//   r1_max_i        RITC1 max correlation, new value every cycle
//   r0_thresh_i     RITC0 threshold (quasi-static)
//   r1_thresh_i     RITC1 threshold (quasi-static)
//   mode_i          0=R0 only, 1=R1 only, 2=R0 OR R1, 3=R0 AND R1
//   holdoff_i       dead cycles after a trigger
//   enable_i        trigger enable (only gates leaving IDLE)
//   trig_o          one-cycle trigger pulse
//   trig_max_o      {r1,r0} max values that caused the last trigger
//   scaler_r0_o     R0 over-threshold cycles in the last period
//   scaler_r1_o     R1 over-threshold cycles in the last period
//   scaler_trig_o   accepted triggers in the last period
//   scaler_valid_o  one-cycle pulse when the scaler outputs update
//   busy_o          high while a trigger or its holdoff is in progress
module glitc_trigger_discriminator #(
    parameter int NBITS         = 11,
    parameter int HOLDOFF_BITS  = 8,
    parameter int SCALER_BITS   = 16,
    parameter int SCALER_PERIOD = 162500
) (
    input  logic                    sysclk_i,
    input  logic                    rst_n_i,
    input  logic [NBITS-1:0]        r0_max_i,
    input  logic [NBITS-1:0]        r1_max_i,
    input  logic [NBITS-1:0]        r0_thresh_i,
    input  logic [NBITS-1:0]        r1_thresh_i,
    input  logic [1:0]              mode_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    enable_i,
    output logic                    trig_o,
    output logic [2*NBITS-1:0]      trig_max_o,
    output logic [SCALER_BITS-1:0]  scaler_r0_o,
    output logic [SCALER_BITS-1:0]  scaler_r1_o,
    output logic [SCALER_BITS-1:0]  scaler_trig_o,
    output logic                    scaler_valid_o,
    output logic                    busy_o
);

    localparam int                       PCNT_BITS  = $clog2(SCALER_PERIOD);
    localparam logic [PCNT_BITS-1:0]     PCNT_ZERO  = PCNT_BITS'(0);
    localparam logic [PCNT_BITS-1:0]     PCNT_ONE   = PCNT_BITS'(1);
    localparam logic [PCNT_BITS-1:0]     PCNT_LAST  = PCNT_BITS'(SCALER_PERIOD - 1);
    localparam logic [HOLDOFF_BITS-1:0]  HOLD_ZERO  = HOLDOFF_BITS'(0);
    localparam logic [HOLDOFF_BITS-1:0]  HOLD_ONE   = HOLDOFF_BITS'(1);
    localparam logic [SCALER_BITS-1:0]   SCALER_ZERO = SCALER_BITS'(0);
    localparam logic [SCALER_BITS-1:0]   SCALER_ONE  = SCALER_BITS'(1);
    localparam logic [SCALER_BITS-1:0]   SCALER_MAX  = {SCALER_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Saturating increment used by all three rate accumulators.
    function automatic logic [SCALER_BITS-1:0] sat_inc(
        input logic [SCALER_BITS-1:0] value,
        input logic                   event_hit
    );
        logic [SCALER_BITS-1:0] result;
        if (event_hit && (value != SCALER_MAX)) begin
            result = value + SCALER_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic                    over0_r;
    logic                    over1_r;
    logic [NBITS-1:0]        r0_q_r;
    logic [NBITS-1:0]        r1_q_r;
    logic                    hit_s;
    logic                    go_s;
    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [HOLDOFF_BITS-1:0] hold_cnt_r;
    logic [HOLDOFF_BITS-1:0] hold_cnt_nxt_s;
    logic                    fire_s;
    logic                    trig_r;
    logic [2*NBITS-1:0]      trig_max_r;
    logic                    busy_r;
    logic [PCNT_BITS-1:0]    period_cnt_r;
    logic                    wrap_s;
    logic [SCALER_BITS-1:0]  acc0_r;
    logic [SCALER_BITS-1:0]  acc1_r;
    logic [SCALER_BITS-1:0]  acct_r;
    logic [SCALER_BITS-1:0]  scaler_r0_r;
    logic [SCALER_BITS-1:0]  scaler_r1_r;
    logic [SCALER_BITS-1:0]  scaler_trig_r;
    logic                    scaler_valid_r;

    // Stage 1: strict unsigned threshold compare, registered alongside the raw values.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            over0_r <= 1'b0;
            over1_r <= 1'b0;
            r0_q_r  <= {NBITS{1'b0}};
            r1_q_r  <= {NBITS{1'b0}};
        end else begin
            over0_r <= (r0_max_i > r0_thresh_i);
            over1_r <= (r1_max_i > r1_thresh_i);
            r0_q_r  <= r0_max_i;
            r1_q_r  <= r1_max_i;
        end
    end

    // Coincidence qualification of the stage-1 compare results.
    always_comb begin
        hit_s = 1'b0;
        case (mode_i)
            2'd0:    hit_s = over0_r;
            2'd1:    hit_s = over1_r;
            2'd2:    hit_s = over0_r | over1_r;
            2'd3:    hit_s = over0_r & over1_r;
            default: hit_s = 1'b0;
        endcase
    end

    assign go_s = hit_s & enable_i;

    // Trigger FSM state and holdoff counter registers.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= HOLD_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    // Trigger FSM next state. Leaving FIRE (no holdoff) or the last holdoff
    // cycle re-evaluates the IDLE condition directly, so the trigger spacing
    // is holdoff+1 and a steady hit with zero holdoff fires every cycle.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    state_nxt_s = ST_FIRE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FIRE: begin
                if (holdoff_i != HOLD_ZERO) begin
                    state_nxt_s    = ST_HOLDOFF;
                    hold_cnt_nxt_s = holdoff_i;
                end else if (go_s) begin
                    state_nxt_s = ST_FIRE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_r == HOLD_ONE) begin
                    hold_cnt_nxt_s = HOLD_ZERO;
                    if (go_s) begin
                        state_nxt_s = ST_FIRE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r - HOLD_ONE;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                hold_cnt_nxt_s = HOLD_ZERO;
            end
        endcase
    end

    assign fire_s = (state_nxt_s == ST_FIRE);

    // Registered trigger outputs, aligned with the FSM state register.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_r     <= 1'b0;
            busy_r     <= 1'b0;
            trig_max_r <= {(2*NBITS){1'b0}};
        end else begin
            trig_r <= fire_s;
            busy_r <= (state_nxt_s != ST_IDLE);
            if (fire_s) begin
                trig_max_r <= {r1_q_r, r0_q_r};
            end else begin
                trig_max_r <= trig_max_r;
            end
        end
    end

    assign wrap_s = (period_cnt_r == PCNT_LAST);

    // Scaler period counter plus accumulators; on the wrap cycle the
    // accumulators (including that cycle's events) publish and clear.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            period_cnt_r   <= PCNT_ZERO;
            acc0_r         <= SCALER_ZERO;
            acc1_r         <= SCALER_ZERO;
            acct_r         <= SCALER_ZERO;
            scaler_r0_r    <= SCALER_ZERO;
            scaler_r1_r    <= SCALER_ZERO;
            scaler_trig_r  <= SCALER_ZERO;
            scaler_valid_r <= 1'b0;
        end else begin
            scaler_valid_r <= wrap_s;
            if (wrap_s) begin
                period_cnt_r  <= PCNT_ZERO;
                scaler_r0_r   <= sat_inc(acc0_r, over0_r);
                scaler_r1_r   <= sat_inc(acc1_r, over1_r);
                scaler_trig_r <= sat_inc(acct_r, trig_r);
                acc0_r        <= SCALER_ZERO;
                acc1_r        <= SCALER_ZERO;
                acct_r        <= SCALER_ZERO;
            end else begin
                period_cnt_r  <= period_cnt_r + PCNT_ONE;
                acc0_r        <= sat_inc(acc0_r, over0_r);
                acc1_r        <= sat_inc(acc1_r, over1_r);
                acct_r        <= sat_inc(acct_r, trig_r);
            end
        end
    end

    assign trig_o         = trig_r;
    assign trig_max_o     = trig_max_r;
    assign busy_o         = busy_r;
    assign scaler_r0_o    = scaler_r0_r;
    assign scaler_r1_o    = scaler_r1_r;
    assign scaler_trig_o  = scaler_trig_r;
    assign scaler_valid_o = scaler_valid_r;

endmodule

// File: tb/tb_glitc_trigger_discriminator.sv
// Testbench for glitc_trigger_discriminator. It applies directed and randomized
// stimulus. A reference model works on whole cycles: it decides the trigger
// times and the holdoff windows, and it sums the events in each scaler period.
// It queues the expected trigger and scaler events, and a monitor on the
// falling edge checks the DUT outputs against them.
module tb_glitc_trigger_discriminator;

    localparam int NB = 11;
    localparam int HB = 8;
    localparam int SB = 4;
    localparam int SP = 16;
    localparam int SMAX = (1 << SB) - 1;

    logic            sysclk = 1'b0;
    logic            rst_n  = 1'b1;
    logic [NB-1:0]   r0_max = '0;
    logic [NB-1:0]   r1_max = '0;
    logic [NB-1:0]   r0_thresh = '0;
    logic [NB-1:0]   r1_thresh = '0;
    logic [1:0]      mode = 2'd0;
    logic [HB-1:0]   holdoff = '0;
    logic            enable = 1'b0;
    logic            trig_o;
    logic [2*NB-1:0] trig_max_o;
    logic [SB-1:0]   scaler_r0_o, scaler_r1_o, scaler_trig_o;
    logic            scaler_valid_o, busy_o;

    always #5 sysclk = ~sysclk;

    glitc_trigger_discriminator #(
        .NBITS(NB), .HOLDOFF_BITS(HB), .SCALER_BITS(SB), .SCALER_PERIOD(SP)
    ) dut (
        .sysclk_i(sysclk), .rst_n_i(rst_n),
        .r0_max_i(r0_max), .r1_max_i(r1_max),
        .r0_thresh_i(r0_thresh), .r1_thresh_i(r1_thresh),
        .mode_i(mode), .holdoff_i(holdoff), .enable_i(enable),
        .trig_o(trig_o), .trig_max_o(trig_max_o),
        .scaler_r0_o(scaler_r0_o), .scaler_r1_o(scaler_r1_o),
        .scaler_trig_o(scaler_trig_o), .scaler_valid_o(scaler_valid_o),
        .busy_o(busy_o)
    );

    typedef struct { int cyc; logic [2*NB-1:0] mx; } texp_t;
    typedef struct { int cyc; int s0; int s1; int st; } sexp_t;

    texp_t tq[$];
    sexp_t sq[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    active = 1'b0;
    bit    exp_busy = 1'b0;

    // model state
    int              next_ok, acc0, acc1, acct;
    bit              ov0_d1, ov0_d2, ov1_d1, ov1_d2, en_d1;
    logic [NB-1:0]   r0_d1, r0_d2, r1_d1, r1_d2;
    logic [1:0]      mode_d1;

    // monitor-held copies of the last published values
    logic [2*NB-1:0] last_max;
    int              last_s0, last_s1, last_st;
    bit              m_et, m_es;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    task automatic model_reset();
        tq.delete();
        sq.delete();
        next_ok = 0; acc0 = 0; acc1 = 0; acct = 0;
        ov0_d1 = 0; ov0_d2 = 0; ov1_d1 = 0; ov1_d2 = 0; en_d1 = 0;
        r0_d1 = '0; r0_d2 = '0; r1_d1 = '0; r1_d2 = '0; mode_d1 = 2'd0;
        last_max = '0; last_s0 = 0; last_s1 = 0; last_st = 0;
        exp_busy = 1'b0;
    endtask

    // Drives one cycle of inputs, updates the reference model, then advances.
    task automatic step(input logic [NB-1:0] a, input logic [NB-1:0] b);
        bit ov0, ov1, hit, trig;
        r0_max = a;
        r1_max = b;
        ov0 = (a > r0_thresh);
        ov1 = (b > r1_thresh);
        case (mode_d1)
            2'd0:    hit = ov0_d2;
            2'd1:    hit = ov1_d2;
            2'd2:    hit = ov0_d2 || ov1_d2;
            default: hit = ov0_d2 && ov1_d2;
        endcase
        trig = hit && en_d1 && (cyc >= next_ok);
        if (trig) begin
            tq.push_back('{cyc, {r1_d2, r0_d2}});
            next_ok = cyc + int'(holdoff) + 1;
        end
        exp_busy = (cyc < next_ok);
        acc0 = sat(acc0 + int'(ov0_d1));
        acc1 = sat(acc1 + int'(ov1_d1));
        acct = sat(acct + int'(trig));
        if ((cyc % SP) == SP - 1) begin
            sq.push_back('{cyc + 1, acc0, acc1, acct});
            acc0 = 0; acc1 = 0; acct = 0;
        end
        ov0_d2 = ov0_d1; ov1_d2 = ov1_d1; r0_d2 = r0_d1; r1_d2 = r1_d1;
        ov0_d1 = ov0;    ov1_d1 = ov1;    r0_d1 = a;     r1_d1 = b;
        mode_d1 = mode;
        en_d1 = enable;
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    // Asserts reset just after an edge, checks the asynchronous clear, releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst trig_o", 32'(trig_o), 32'd0);
        chk("rst trig_max_o", 32'(trig_max_o), 32'd0);
        chk("rst busy_o", 32'(busy_o), 32'd0);
        chk("rst scaler_valid_o", 32'(scaler_valid_o), 32'd0);
        chk("rst scaler_r0_o", 32'(scaler_r0_o), 32'd0);
        chk("rst scaler_r1_o", 32'(scaler_r1_o), 32'd0);
        chk("rst scaler_trig_o", 32'(scaler_trig_o), 32'd0);
        model_reset();
        repeat (2) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        active = 1'b1;
    endtask

    function automatic logic [NB-1:0] near(input logic [NB-1:0] th);
        int v, d;
        if ($urandom_range(0, 2) == 0) begin
            v = int'($urandom_range(0, 2047));
        end else begin
            d = int'($urandom_range(0, 4));
            v = int'(th) + d - 2;
        end
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        return NB'(v);
    endfunction

    // Monitor: compares DUT outputs to the scoreboard queues on the falling edge.
    always @(negedge sysclk) begin
        if (active && rst_n) begin
            m_et = (tq.size() > 0) && (tq[0].cyc == cyc);
            chk("trig_o", 32'(trig_o), 32'(m_et));
            if (m_et) begin
                last_max = tq[0].mx;
                void'(tq.pop_front());
            end
            chk("trig_max_o", 32'(trig_max_o), 32'(last_max));
            chk("busy_o", 32'(busy_o), 32'(exp_busy));
            m_es = (sq.size() > 0) && (sq[0].cyc == cyc);
            chk("scaler_valid_o", 32'(scaler_valid_o), 32'(m_es));
            if (m_es) begin
                last_s0 = sq[0].s0;
                last_s1 = sq[0].s1;
                last_st = sq[0].st;
                void'(sq.pop_front());
            end
            chk("scaler_r0_o", 32'(scaler_r0_o), 32'(last_s0));
            chk("scaler_r1_o", 32'(scaler_r1_o), 32'(last_s1));
            chk("scaler_trig_o", 32'(scaler_trig_o), 32'(last_st));
        end
    end

    initial begin
        model_reset();
        #2;
        do_reset();

        // Basic trigger, latency, capture and strict compare.
        mode = 2'd0; r0_thresh = 11'd100; r1_thresh = 11'd100; holdoff = 8'd4; enable = 1'b1;
        repeat (3) step(11'd0, 11'd0);
        step(11'd101, 11'd0);
        repeat (8) step(11'd0, 11'd0);
        step(11'd100, 11'd0);
        repeat (6) step(11'd0, 11'd0);

        // Coincidence modes.
        r0_thresh = 11'd200; r1_thresh = 11'd200; holdoff = 8'd0;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            repeat (2) step(11'd0, 11'd0);
            step(11'd300, 11'd150);
            repeat (3) step(11'd0, 11'd0);
        end
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            repeat (2) step(11'd0, 11'd0);
            step(11'd300, 11'd300);
            repeat (3) step(11'd0, 11'd0);
        end

        // Holdoff spacing.
        mode = 2'd0; holdoff = 8'd3;
        repeat (14) step(11'd2047, 11'd0);
        repeat (6) step(11'd0, 11'd0);
        holdoff = 8'd0;
        repeat (8) step(11'd2047, 11'd0);
        repeat (4) step(11'd0, 11'd0);

        // Enable gating, and enable dropped during holdoff.
        enable = 1'b0;
        repeat (10) step(11'd2047, 11'd0);
        enable = 1'b1;
        repeat (3) step(11'd0, 11'd0);
        holdoff = 8'd6;
        repeat (3) step(11'd2047, 11'd0);
        enable = 1'b0;
        repeat (10) step(11'd2047, 11'd0);
        enable = 1'b1;
        repeat (4) step(11'd0, 11'd0);

        // Scaler placement around the wrap, aligned to a fresh period.
        do_reset();
        mode = 2'd1; r0_thresh = 11'd200; r1_thresh = 11'd200; holdoff = 8'd0;
        for (int k = 0; k < 32; k++) begin
            if (k == 3 || k == 7 || k == 9 || k == 12 || k == 14 || k == 15) begin
                step(11'd500, 11'd0);
            end else begin
                step(11'd0, 11'd0);
            end
        end
        // Saturation: every cycle over on both, triggering every cycle.
        mode = 2'd3;
        repeat (34) step(11'd2047, 11'd2047);
        repeat (20) step(11'd0, 11'd0);

        // Reset in the middle of a holdoff and a period.
        mode = 2'd0; holdoff = 8'd20;
        repeat (5) step(11'd2047, 11'd0);
        do_reset();
        repeat (40) step(11'd0, 11'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ((i % 300) == 0) begin
                r0_thresh = NB'($urandom_range(0, 2047));
                r1_thresh = NB'($urandom_range(0, 2047));
            end
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) holdoff = HB'($urandom_range(0, 5));
            enable = ($urandom_range(0, 9) != 0);
            if (i == 777) do_reset();
            step(near(r0_thresh), near(r1_thresh));
        end
        repeat (20) step(11'd0, 11'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
